// File: rtl/vector_pkg.sv
// Shared vector-unit types.
// Holds the register selector, the FP16 lane types and the writeback beat
// exchanged between the lane functional units and the register-file write port.
package vector_pkg;

  // Vector register file geometry.
  localparam int VREG_NUM   = 32;
  localparam int SLICE_W    = 3;   // slices per vector register = 2**SLICE_W

  // Writeback path geometry.
  localparam int LANE_W     = 4;   // FP16 elements per writeback beat
  localparam int NUM_WB_REQ = 4;   // ALU, MUL, DIV, SQRT

  typedef logic [$clog2(VREG_NUM)-1:0] vsel_t;
  typedef logic [15:0]                 fp16_t;
  typedef logic [SLICE_W-1:0]          slice_t;
  typedef fp16_t [LANE_W-1:0]          lane_data_t;
  typedef logic [LANE_W-1:0]           lane_mask_t;

  // One register-file write beat. Masked-off lanes still carry data; the
  // register file applies the mask.
  typedef struct packed {
    vsel_t      vd;
    slice_t     slice;
    lane_data_t data;
    lane_mask_t mask;
    logic       last;   // final beat of this vd burst
  } wb_beat_t;

  // ARB: round-robin among all requesters. LOCK: a burst is in progress and
  // only its owner may be granted until its last beat.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } wb_arb_state_t;

endpackage

// File: rtl/vector_wb_arbiter_rr_pick.sv
// rr_pick: round-robin priority pick.
// Scans valid starting at ptr, then ptr+1, ... modulo NUM_REQ, and returns the
// first valid requester as a one-hot grant plus its index.
//   ptr   - highest-priority requester index (must be < NUM_REQ)
//   valid - request vector
//   grant - one-hot grant, all zero when nothing is valid
//   idx   - index of the granted requester (0 when nothing is valid)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int   j;
    logic found;
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/vector_wb_arbiter.sv
// vector_wb_arbiter: merges writeback beats from NUM_REQ lane functional
// units onto the single register-file write port.
// Round-robin between requesters; once a burst starts (beat with last=0) the
// port is locked to that requester until its last beat, so beats of one vd are
// never interleaved. One output register gives full throughput with
// valid/ready backpressure.
//   CLK, nRST  - clock, synchronous active-low reset
//   req_valid  - per-requester beat valid
//   req_in     - per-requester beat
//   req_ready  - per-requester accept (at most one high)
//   wb_valid   - write beat valid
//   wb_out     - write beat
//   wb_ready   - register file accepts wb_out
//   wb_owner   - requester that produced wb_out
//   busy       - burst lock held or wb_valid high
module vector_wb_arbiter
  import vector_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ,
  parameter int LANE_W  = vector_pkg::LANE_W
) (
  input  logic                                            CLK,
  input  logic                                            nRST,
  input  logic [NUM_REQ-1:0]                              req_valid,
  input  wb_beat_t [NUM_REQ-1:0]                          req_in,
  output logic [NUM_REQ-1:0]                              req_ready,
  output logic                                            wb_valid,
  output wb_beat_t                                        wb_out,
  input  logic                                            wb_ready,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] wb_owner,
  output logic                                            busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // The beat layout is fixed by the package; the parameter only documents it.
  if (LANE_W != vector_pkg::LANE_W) begin : g_lane_w_check
    $error("LANE_W must equal vector_pkg::LANE_W");
  end

  wb_arb_state_t      state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   lock_id_q, lock_id_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   sel_idx;
  logic               accept_en;
  logic               xfer;
  wb_beat_t           sel_beat;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(NUM_REQ - 1)) return '0;
    return i + IDX_W'(1);
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .ptr   (rr_ptr_q),
    .valid (req_valid),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // The output slot can take a new beat when it is empty or draining now.
  assign accept_en = !wb_valid || wb_ready;
  // Gating with nRST keeps req_ready low during reset, so nothing is consumed
  // from a requester while its beat would be discarded anyway.
  assign req_ready = (nRST && accept_en) ? grant : '0;
  assign xfer      = |req_ready;
  assign sel_beat  = req_in[sel_idx];
  assign busy      = (state_q == LOCK) || wb_valid;

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!nRST) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Next-state logic. No transfer (including accept_en low) means no change.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    case (state_q)
      ARB: begin
        if (xfer) begin
          if (sel_beat.last) begin
            rr_ptr_d = wrap_inc(sel_idx);
          end else begin
            lock_id_d = sel_idx;
            state_d   = LOCK;
          end
        end
      end
      LOCK: begin
        if (xfer && sel_beat.last) begin
          rr_ptr_d = wrap_inc(lock_id_q);
          state_d  = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Grant selection. In LOCK only the lock owner is considered, so a bubble
  // from the owner simply yields no grant.
  always_comb begin
    grant   = '0;
    sel_idx = lock_id_q;
    case (state_q)
      ARB: begin
        grant   = pick_grant;
        sel_idx = pick_idx;
      end
      LOCK: begin
        grant[lock_id_q] = req_valid[lock_id_q];
        sel_idx          = lock_id_q;
      end
      default: ;
    endcase
  end

  // Output register: holds while stalled, reloads or empties when draining.
  always_ff @(posedge CLK) begin
    // NOTE: the beat payload is reset too, so wb_out reads as zero after reset
    // instead of exposing a discarded in-flight beat.
    if (!nRST) begin
      wb_valid <= 1'b0;
      wb_out   <= '0;
      wb_owner <= '0;
    end else if (accept_en) begin
      wb_valid <= xfer;
      if (xfer) begin
        wb_out   <= sel_beat;
        wb_owner <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_vector_wb_arbiter.sv
// Self-checking bench for vector_wb_arbiter: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (burst lock, lock bubble,
// reset mid-burst).
module tb_vector_wb_arbiter;
  import vector_pkg::*;

  localparam int N = 4;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [N-1:0]        req_valid;
  wb_beat_t [N-1:0]    req_in;
  logic [N-1:0]        req_ready;
  logic                wb_valid;
  wb_beat_t            wb_out;
  logic                wb_ready;
  logic [1:0]          wb_owner;
  logic                busy;

  int total = 0;
  int bad   = 0;

  vector_wb_arbiter #(.NUM_REQ(N), .LANE_W(4)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_in    (req_in),
    .req_ready (req_ready),
    .wb_valid  (wb_valid),
    .wb_out    (wb_out),
    .wb_ready  (wb_ready),
    .wb_owner  (wb_owner),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Distinct, recognisable beat for requester i, slice s.
  function automatic wb_beat_t make_beat(input int i, input int s, input logic l);
    wb_beat_t b;
    b.vd    = vsel_t'(i + 1);
    b.slice = slice_t'(s);
    for (int e = 0; e < 4; e++) b.data[e] = fp16_t'(16'h1000 * i + 16'h0100 * s + e);
    b.mask  = lane_mask_t'(i * 5 + s);
    b.last  = l;
    return b;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input int s, input logic l);
    req_valid[i] = v;
    req_in[i]    = make_beat(i, s, l);
  endtask

  // Let inputs settle, check req_ready, then advance past the next edge.
  task automatic tick(input string name, input logic [N-1:0] exp_ready);
    #1;
    check({name, ".req_ready"}, 128'(req_ready), 128'(exp_ready));
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string name, input logic wv, input int owner,
                         input logic bz, input wb_beat_t beat);
    check({name, ".wb_valid"}, 128'(wb_valid), 128'(wv));
    check({name, ".busy"}, 128'(busy), 128'(bz));
    if (wv) begin
      check({name, ".wb_owner"}, 128'(wb_owner), 128'(owner));
      check({name, ".wb_out"}, 128'(wb_out), 128'(beat));
    end
  endtask

  typedef struct {
    logic         nrst;
    logic [N-1:0] valid;
    logic         wr;
    logic [N-1:0] exp_ready;
    logic         exp_wv;
    int           exp_owner;
    logic         exp_busy;
  } vec_t;

  vec_t tbl [20];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // All table beats are slice 0, last=1.
    tbl[0]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 0, 1'b0}; // reset
    tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 0, 1'b1}; // first cycle out of reset
    tbl[2]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 1, 1'b1};
    tbl[3]  = '{1'b1, 4'hF, 1'b1, 4'h4, 1'b1, 2, 1'b1};
    tbl[4]  = '{1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 3, 1'b1};
    tbl[5]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 0, 1'b1}; // wrap to 0
    tbl[6]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 0, 1'b0}; // drain
    tbl[7]  = '{1'b1, 4'h4, 1'b1, 4'h4, 1'b1, 2, 1'b1}; // lone req2
    tbl[8]  = '{1'b1, 4'h4, 1'b1, 4'h4, 1'b1, 2, 1'b1};
    tbl[9]  = '{1'b1, 4'h4, 1'b1, 4'h4, 1'b1, 2, 1'b1};
    tbl[10] = '{1'b1, 4'hF, 1'b1, 4'h8, 1'b1, 3, 1'b1}; // rr_ptr was 3
    tbl[11] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 3, 1'b1}; // stall x3
    tbl[12] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 3, 1'b1};
    tbl[13] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 3, 1'b1};
    tbl[14] = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 0, 1'b1}; // no gap after stall
    tbl[15] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 0, 1'b0};
    tbl[16] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 0, 1'b0}; // empty slot accepts
    tbl[17] = '{1'b1, 4'h2, 1'b0, 4'h2, 1'b1, 1, 1'b1};
    tbl[18] = '{1'b1, 4'h2, 1'b0, 4'h0, 1'b1, 1, 1'b1}; // full, not draining
    tbl[19] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1, 1'b0};

    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 1'b1);

    for (int v = 0; v < 20; v++) begin
      string nm;
      nm       = $sformatf("vec%0d", v);
      nRST     = tbl[v].nrst;
      wb_ready = tbl[v].wr;
      for (int i = 0; i < N; i++) set_req(i, tbl[v].valid[i], 0, 1'b1);
      tick(nm, tbl[v].exp_ready);
      chk_out(nm, tbl[v].exp_wv, tbl[v].exp_owner, tbl[v].exp_busy,
              make_beat(tbl[v].exp_owner, 0, 1'b1));
      if (!tbl[v].nrst) check({nm, ".wb_owner_rst"}, 128'(wb_owner), 128'(0));
    end

    // Burst from req1 is not interleaved with req0/req2.
    wb_ready = 1'b1;
    nRST = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 1'b1);
    tick("burst_rst", 4'h0);
    nRST = 1'b1;
    set_req(0, 1'b1, 0, 1'b1);
    tick("burst_pre", 4'h1);                 // rr_ptr -> 1
    set_req(2, 1'b1, 0, 1'b1);
    for (int s = 0; s < 4; s++) begin
      set_req(1, 1'b1, s, s == 3);
      tick($sformatf("burst_s%0d", s), 4'h2);
      chk_out($sformatf("burst_s%0d", s), 1'b1, 1, 1'b1, make_beat(1, s, s == 3));
    end
    set_req(1, 1'b0, 0, 1'b1);
    tick("burst_after", 4'h4);
    chk_out("burst_after", 1'b1, 2, 1'b1, make_beat(2, 0, 1'b1));
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 1'b1);
    tick("burst_idle", 4'h0);
    chk_out("burst_idle", 1'b0, 0, 1'b0, '0);

    // Lock on req3 with a 2-cycle bubble; req0 waits, then rr_ptr wraps to 0.
    set_req(0, 1'b1, 0, 1'b1);
    set_req(1, 1'b1, 0, 1'b1);
    set_req(3, 1'b1, 0, 1'b0);
    tick("lock_s0", 4'h8);
    chk_out("lock_s0", 1'b1, 3, 1'b1, make_beat(3, 0, 1'b0));
    set_req(3, 1'b0, 1, 1'b1);
    for (int b = 0; b < 2; b++) begin
      tick($sformatf("lock_bubble%0d", b), 4'h0);
      chk_out($sformatf("lock_bubble%0d", b), 1'b0, 0, 1'b1, '0);
    end
    set_req(3, 1'b1, 1, 1'b1);
    tick("lock_s1", 4'h8);
    chk_out("lock_s1", 1'b1, 3, 1'b1, make_beat(3, 1, 1'b1));
    set_req(3, 1'b0, 0, 1'b1);
    tick("lock_wrap", 4'h1);
    chk_out("lock_wrap", 1'b1, 0, 1'b1, make_beat(0, 0, 1'b1));
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 0, 1'b1);
    tick("lock_idle", 4'h0);                 // rr_ptr now 1

    // Reset during beat 2 of a 4-beat burst from req1.
    set_req(1, 1'b1, 0, 1'b0);
    tick("rst_s0", 4'h2);
    set_req(1, 1'b1, 1, 1'b0);
    tick("rst_s1", 4'h2);
    chk_out("rst_s1", 1'b1, 1, 1'b1, make_beat(1, 1, 1'b0));
    nRST = 1'b0;
    set_req(1, 1'b1, 2, 1'b0);
    tick("rst_mid", 4'h0);
    chk_out("rst_mid", 1'b0, 0, 1'b0, '0);
    check("rst_mid.wb_out_zero", 128'(wb_out), 128'(0));
    check("rst_mid.wb_owner_zero", 128'(wb_owner), 128'(0));
    nRST = 1'b1;
    set_req(0, 1'b1, 0, 1'b1);
    set_req(1, 1'b1, 3, 1'b1);
    tick("rst_release", 4'h1);
    chk_out("rst_release", 1'b1, 0, 1'b1, make_beat(0, 0, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_wb_arbiter.md
VECTOR_WB_ARBITER -- requirements
Module: vector_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of writeback requesters (lane FUs: ALU, MUL, DIV, SQRT).
REQ-002 Parameter LANE_W, default 4, FP16 elements per writeback beat.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-006 req_in  input  NUM_REQ x wb_beat_t  per-requester beat: vd (vsel_t), slice index, LANE_W x FP16 data, LANE_W mask bits, last flag.
REQ-007 req_ready  output  NUM_REQ  per-requester beat accepted this cycle.
REQ-008 wb_valid  output  1  register-file write beat valid.
REQ-009 wb_out  output  wb_beat_t  beat presented to the register-file write port.
REQ-010 wb_ready  input  1  register file accepts wb_out this cycle.
REQ-011 wb_owner  output  clog2(NUM_REQ)  index of requester that produced wb_out.
REQ-012 busy  output  1  high while a burst lock is held or wb_valid is high.

Function
REQ-013 Transfer on requester i occurs when req_valid[i] and req_ready[i] are both high; at most one req_ready bit high per cycle.
REQ-014 Output stage is one register; accept_en = !wb_valid || wb_ready.
REQ-015 req_ready[i] high only when accept_en is high and i is the granted requester; it never depends on req_valid of other requesters through a loop.
REQ-016 Accepted beat appears on wb_out with wb_valid high the next cycle (latency 1); wb_out and wb_owner stay stable while wb_valid && !wb_ready.
REQ-017 If wb_ready high and no beat accepted, wb_valid clears next cycle; if a beat is accepted the same cycle, wb_valid stays high with the new beat (full throughput, one beat/cycle).
REQ-018 FSM states: ARB, LOCK.
REQ-019 ARB: grant = first valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ; no valid requester -> no grant, state unchanged.
REQ-020 ARB, transfer with last=1: rr_ptr <= granted+1 modulo NUM_REQ (wrap NUM_REQ-1 -> 0), stay ARB.
REQ-021 ARB, transfer with last=0: lock_id <= granted, go LOCK.
REQ-022 LOCK: only lock_id may be granted, regardless of other req_valid; beats of one vd burst are never interleaved.
REQ-023 LOCK, transfer with last=1: rr_ptr <= lock_id+1 modulo NUM_REQ, go ARB.
REQ-024 LOCK with req_valid[lock_id] low: no grant, stay LOCK (bubble allowed, no timeout).
REQ-025 accept_en low: no req_ready, no state, rr_ptr or lock change.
REQ-026 Beat contents pass unmodified; masked-off elements are still forwarded, mask applied by the register file.
REQ-027 busy = (state == LOCK) || wb_valid.

Reset
REQ-028 While nRST low at a clock edge: wb_valid=0, wb_out=0, wb_owner=0, req_ready=0, state=ARB, rr_ptr=0, lock_id=0.
REQ-029 Reset mid-burst or with wb_valid high discards the in-flight beat and lock; no beat is emitted for it after reset.
REQ-030 First grant after reset release can occur in the first cycle nRST is high.

Structure
REQ-031 wb_beat_t, LANE_W and NUM_WB_REQ belong in vector_pkg next to vsel_t and the lane types.
REQ-032 Round-robin priority pick (rr_ptr, valid vector -> one-hot grant, index) is one sub-module, rr_pick; FSM and output register stay in vector_wb_arbiter.

Verification
REQ-033 Reset, then all four requesters assert valid, last=1, wb_ready held high -> owners 0,1,2,3,0 on consecutive cycles, one wb_valid beat per cycle.
REQ-034 Req1 sends 4-beat burst (slices 0..3, last on slice 3) while req0 and req2 are valid -> wb_owner=1 for four consecutive beats, then grant goes to req2.
REQ-035 wb_ready low for 3 cycles with wb_valid high -> wb_out and wb_owner stable, all req_ready low; wb_ready high -> next beat follows with no gap.
REQ-036 Lock on req3, req3 drops valid for 2 cycles while req0 valid -> no grant for 2 cycles, req0 not served until req3 last beat, then rr_ptr wraps to 0.
REQ-037 nRST low during beat 2 of a 4-beat burst -> next cycle wb_valid=0, busy=0; after release req0 with last=1 is granted first.
REQ-038 Single requester 2 valid continuously with last=1, others idle -> granted every cycle, rr_ptr ends at 3 each time.
